// File: rtl/divisor_arbiter.sv
// divisor_arbiter: round-robin front end that shares one sequential divider
// among NREQ requesters. It accepts one request at a time, issues a single
// start pulse to the divider, and returns quotient/remainder with a one-cycle
// response pulse. Divide-by-zero is answered locally. A watchdog aborts
// operations that the divider never completes.
module divisor_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_dividendo,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_quociente,
  output logic [W-1:0]      rsp_resto,
  output logic              rsp_div_zero,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              div_start,
  output logic [W-1:0]      div_dividendo,
  output logic [W-1:0]      div_divisor,
  input  logic              div_ready,
  input  logic              div_done_tick,
  input  logic [W-1:0]      div_quociente,
  input  logic [W-1:0]      div_resto
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // The watchdog only ever counts up to TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          divz_q, divz_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] wdog_q, wdog_d;

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand_idx;
  logic          accept;
  logic [W-1:0]  dvd_arr [NREQ];
  logic [W-1:0]  dvs_arr [NREQ];
  logic [W-1:0]  sel_dividend;
  logic [W-1:0]  sel_divisor;

  // Unpack the flat operand buses so the granted pair can be picked by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign dvd_arr[gi] = req_dividendo[gi*W +: W];
    assign dvs_arr[gi] = req_divisor[gi*W +: W];
  end

  assign sel_dividend = dvd_arr[grant_idx];
  assign sel_divisor  = dvs_arr[grant_idx];

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // A grant only happens in IDLE with an idle divider; masked while in reset
  // so every output reads zero the moment reset is applied.
  assign accept = (state_q == S_IDLE) && div_ready && grant_found && !rst;

  // One-hot accept and response strobes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_strobe
    assign req_ready[gi] = accept && (grant_idx == IW'(gi));
    assign rsp_valid[gi] = (state_q == S_RESP) && (grant_q == IW'(gi));
  end

  assign div_start     = (state_q == S_ISSUE);
  assign busy          = (state_q != S_IDLE);
  assign div_dividendo = opa_q;
  assign div_divisor   = opb_q;
  assign rsp_quociente = quo_q;
  assign rsp_resto     = rem_q;
  assign rsp_div_zero  = divz_q;
  assign rsp_timeout   = tmo_q;

  // Next-state logic: grant, issue, wait with watchdog, respond.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    divz_d       = divz_q;
    tmo_d        = tmo_q;
    wdog_d       = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_d = grant_idx;
          opa_d   = sel_dividend;
          opb_d   = sel_divisor;
          if (sel_divisor == '0) begin
            // Answer locally; the divider is never started.
            quo_d   = '1;
            rem_d   = sel_dividend;
            divz_d  = 1'b1;
            tmo_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the same cycle as the watchdog limit still wins.
        if (div_done_tick) begin
          quo_d   = div_quociente;
          rem_d   = div_resto;
          divz_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else if (wdog_q == WD_LIMIT) begin
          quo_d   = '0;
          rem_d   = '0;
          divz_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q + CW'(1);
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_RST;
      grant_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      divz_q       <= 1'b0;
      tmo_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      divz_q       <= divz_d;
      tmo_q        <= tmo_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule

// File: tb/tb_divisor_arbiter.sv
// Testbench for divisor_arbiter: directed steps with a behavioural divider,
// expected grants and responses queued at stimulus time and checked on output.
`timescale 1ns/1ps
module tb_divisor_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_dividendo = '0;
  logic [NREQ*W-1:0] req_divisor = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_quociente;
  logic [W-1:0]      rsp_resto;
  logic              rsp_div_zero;
  logic              rsp_timeout;
  logic              busy;
  logic              div_start;
  logic [W-1:0]      div_dividendo;
  logic [W-1:0]      div_divisor;
  logic              div_ready;
  logic              div_done_tick = 1'b0;
  logic [W-1:0]      div_quociente = '0;
  logic [W-1:0]      div_resto = '0;

  divisor_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dividendo (req_dividendo),
    .req_divisor   (req_divisor),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_quociente (rsp_quociente),
    .rsp_resto     (rsp_resto),
    .rsp_div_zero  (rsp_div_zero),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .div_start     (div_start),
    .div_dividendo (div_dividendo),
    .div_divisor   (div_divisor),
    .div_ready     (div_ready),
    .div_done_tick (div_done_tick),
    .div_quociente (div_quociente),
    .div_resto     (div_resto)
  );

  always #5 clk = ~clk;

  // Behavioural divider: fixed latency, or never completes when hang is set.
  int       lat = 3;
  bit       hang = 1'b0;
  bit       ready_en = 1'b1;
  logic     m_busy = 1'b0;
  int       m_cnt = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;

  assign div_ready = ready_en && !m_busy;

  always @(posedge clk) begin
    div_done_tick <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy        <= 1'b0;
        div_done_tick <= 1'b1;
        div_quociente <= m_a / m_b;
        div_resto     <= m_a % m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (div_start && !hang) begin
      m_busy <= 1'b1;
      m_cnt  <= lat;
      m_a    <= div_dividendo;
      m_b    <= div_divisor;
    end
  end

  typedef struct {
    int           idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         to;
  } exp_t;

  exp_t         exp_q[$];
  int           exp_grant[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           start_cyc = 0;
  int           done_cyc = 0;
  int           n_start = 0;
  int           starts_at_acc = 0;
  logic [W-1:0] cur_a = '0;
  logic [W-1:0] cur_b = '0;
  logic [W-1:0] last_q = '0;
  logic [NREQ-1:0] obs_ready = '0;
  int           rem_grants[NREQ];
  bit           drop_pend[NREQ];

  function automatic logic [NREQ-1:0] onehot(input int i);
    onehot = NREQ'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, {req_ready, rsp_valid, rsp_div_zero, rsp_timeout, busy, div_start}, 0);
    chk({tag, "_rsp_data"}, {rsp_quociente, rsp_resto}, 0);
    chk({tag, "_div_ops"}, {div_dividendo, div_divisor}, 0);
  endtask

  task automatic req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividendo[i*W +: W] = a;
    req_divisor[i*W +: W]   = b;
    rem_grants[i] = 1;
    req_valid = req_valid | onehot(i);
  endtask

  // Look at everything the DUT shows in the current cycle.
  task automatic observe();
    int   g;
    int   eg;
    exp_t e;
    g = 0;
    obs_ready = req_ready;
    if (req_ready != '0) begin
      for (int i = NREQ - 1; i >= 0; i--) if ((req_ready & onehot(i)) != '0) g = i;
      if (exp_grant.size() == 0) begin
        chk("unexpected_grant", req_ready, 0);
      end else begin
        eg = exp_grant.pop_front();
        chk("grant", req_ready, onehot(eg));
      end
      acc_cyc       = cyc;
      starts_at_acc = n_start;
      cur_a = W'(req_dividendo >> (g * W));
      cur_b = W'(req_divisor >> (g * W));
      e.idx = g;
      if (cur_b == '0) begin
        e.q = '1; e.r = cur_a; e.dz = 1'b1; e.to = 1'b0;
      end else if (hang) begin
        e.q = '0; e.r = '0; e.dz = 1'b0; e.to = 1'b1;
      end else begin
        e.q = cur_a / cur_b; e.r = cur_a % cur_b; e.dz = 1'b0; e.to = 1'b0;
      end
      exp_q.push_back(e);
      rem_grants[g] = rem_grants[g] - 1;
      if (rem_grants[g] <= 0) drop_pend[g] = 1'b1;
    end
    if (div_start) begin
      n_start++;
      start_cyc = cyc;
      chk("start_latency", cyc, acc_cyc + 1);
      chk("div_dividendo", div_dividendo, cur_a);
      chk("div_divisor", div_divisor, cur_b);
    end
    if (div_done_tick) done_cyc = cyc;
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        $display("rsp req%0d q=%0d r=%0d dz=%0b to=%0b cycle=%0d",
                 e.idx, rsp_quociente, rsp_resto, rsp_div_zero, rsp_timeout, cyc);
        chk("rsp_valid", rsp_valid, onehot(e.idx));
        chk("rsp_quociente", rsp_quociente, e.q);
        chk("rsp_resto", rsp_resto, e.r);
        chk("rsp_div_zero", rsp_div_zero, e.dz);
        chk("rsp_timeout", rsp_timeout, e.to);
        chk("busy_in_resp", busy, 1);
        last_q = e.q;
        if (e.dz) begin
          chk("dz_latency", cyc, acc_cyc + 1);
          chk("dz_no_start", n_start, starts_at_acc);
        end else if (e.to) begin
          chk("timeout_latency", cyc, start_cyc + TIMEOUT + 1);
        end else begin
          chk("rsp_latency", cyc, done_cyc + 1);
        end
      end
    end
  endtask

  // Observe at the falling edge; change inputs just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    observe();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (drop_pend[i]) begin
        req_valid = req_valid & ~onehot(i);
        drop_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while ((exp_grant.size() != 0 || exp_q.size() != 0) && k < bound) begin
      cycle();
      k++;
    end
    chk({tag, "_pending"}, exp_grant.size() + exp_q.size(), 0);
    exp_grant.delete();
    exp_q.delete();
    cycle();
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_held"}, rsp_quociente, last_q);
  endtask

  initial begin
    int k;
    int s0;
    for (int i = 0; i < NREQ; i++) begin
      rem_grants[i] = 0;
      drop_pend[i]  = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    cycle();

    // All four requesters: round robin 0,1,2,3 then 0 again.
    req(0, 40, 2); req(1, 30, 1); req(2, 60, 4); req(3, 80, 5);
    rem_grants[0] = 2;
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    wait_done("round_robin", 300);

    // Single request 100/7 -> 14 r 2.
    req(0, 100, 7);
    exp_grant.push_back(0);
    wait_done("basic", 100);

    // Divide by zero answered locally.
    req(1, 55, 0);
    exp_grant.push_back(1);
    wait_done("divzero", 50);

    // Divider never completes -> watchdog abort, then normal recovery.
    hang = 1'b1;
    req(2, 200, 10);
    exp_grant.push_back(2);
    wait_done("timeout", 200);
    hang = 1'b0;
    req(2, 200, 10);
    exp_grant.push_back(2);
    wait_done("after_timeout", 100);

    // Reset while waiting on the divider.
    lat = 20;
    s0 = n_start;
    req(0, 350, 17);
    exp_grant.push_back(0);
    k = 0;
    while (n_start == s0 && k < 20) begin
      cycle();
      k++;
    end
    chk("mid_reset_started", n_start, s0 + 1);
    repeat (5) cycle();
    chk("mid_reset_busy_before", busy, 1);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk_zero("mid_reset");
    exp_q.delete();
    exp_grant.delete();
    repeat (2) cycle();
    rst = 1'b0;
    lat = 3;
    req(2, 1000, 33);
    req(0, 9, 3);
    exp_grant.push_back(0);
    exp_grant.push_back(2);
    wait_done("post_reset", 200);

    // Divider not ready: no grant until it is.
    ready_en = 1'b0;
    req(3, 150, 7);
    exp_grant.push_back(3);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("no_grant_not_ready", obs_ready, 0);
    end
    ready_en = 1'b1;
    wait_done("ready_gate", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
